// File: rtl/background_fade_ctrl.sv
// Background palette lookup, brightness scaling and the frame-synchronous fade FSM.
// Optional feature macro: FADE_FLASH_EN (adds `flash` input and a one-frame full-white override).
module background_fade_ctrl #(
  parameter int FADE_STEP_FRAMES = 2,
  parameter int HOLD_FRAMES      = 30
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       start_fade,
`ifdef FADE_FLASH_EN
  input  logic       flash,
`endif
  input  logic [3:0] pix_index,
  input  logic       pix_valid,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       rgb_valid,
  output logic [4:0] level,
  output logic       busy,
  output logic       done
);
  localparam int STAGES = 2;
  localparam int CMAX   = (FADE_STEP_FRAMES > HOLD_FRAMES) ? FADE_STEP_FRAMES : HOLD_FRAMES;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(FADE_STEP_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

  localparam logic [1:0] S_BRIGHT = 2'd0;
  localparam logic [1:0] S_OUT    = 2'd1;
  localparam logic [1:0] S_DARK   = 2'd2;
  localparam logic [1:0] S_IN     = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic            vsync_d;
  logic            fe;
  logic [3:0]      pal;
  logic [3:0]      pal_q;
  logic [3:0]      scaled;
  logic [3:0]      pix_out;
  logic [STAGES:1] vld_pipe;

  assign fe        = vsync & ~vsync_d;
  assign busy      = (state != S_BRIGHT);
  assign rgb_valid = vld_pipe[STAGES];

  always_comb begin
    pal = 4'h0;
    case (pix_index)
      4'd0:  pal = 4'h0;  4'd1:  pal = 4'hD;  4'd2:  pal = 4'h7;  4'd3:  pal = 4'hF;
      4'd4:  pal = 4'h4;  4'd5:  pal = 4'hA;  4'd6:  pal = 4'h1;  4'd7:  pal = 4'h5;
      4'd8:  pal = 4'hE;  4'd9:  pal = 4'h9;  4'd10: pal = 4'h3;  4'd11: pal = 4'hB;
      4'd12: pal = 4'h6;  4'd13: pal = 4'h8;  4'd14: pal = 4'hC;  default: pal = 4'hF;
    endcase
  end

  // Counter compares before incrementing, so it tops out at CMAX-1 and never wraps.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_BRIGHT;
      level   <= 5'd16;
      cnt     <= '0;
      done    <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
      done    <= 1'b0;
      case (state)
        S_BRIGHT: if (start_fade) begin
          state <= S_OUT;
          cnt   <= '0;
        end
        S_OUT: if (fe) begin
          if (cnt == STEP_LAST) begin
            cnt   <= '0;
            level <= level - 5'd1;
            if (level == 5'd1) state <= S_DARK;
          end else cnt <= cnt + CW'(1);
        end
        S_DARK: if (fe) begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= S_IN;
          end else cnt <= cnt + CW'(1);
        end
        S_IN: if (fe) begin
          if (cnt == STEP_LAST) begin
            cnt   <= '0;
            level <= level + 5'd1;
            if (level == 5'd15) begin
              state <= S_BRIGHT;
              done  <= 1'b1;
            end
          end else cnt <= cnt + CW'(1);
        end
        default: state <= S_BRIGHT;
      endcase
    end
  end

  // Max product is 15*16 = 240, so 8 bits hold it; output is bits [7:4].
  assign scaled = 4'((8'(pal_q) * 8'(level)) >> 4);

`ifdef FADE_FLASH_EN
  logic flash_arm;
  logic flash_active;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_arm    <= 1'b0;
      flash_active <= 1'b0;
    end else if (fe) begin
      flash_active <= flash_arm;
      flash_arm    <= flash;
    end else if (flash) begin
      flash_arm <= 1'b1;
    end
  end

  assign pix_out = flash_active ? 4'hF : scaled;
`else
  assign pix_out = scaled;
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_q    <= 4'h0;
      vld_pipe <= '0;
      red      <= 4'h0;
      green    <= 4'h0;
      blue     <= 4'h0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
      if (pix_valid) pal_q <= pal;
      if (vld_pipe[1]) begin
        red   <= pix_out;
        green <= pix_out;
        blue  <= pix_out;
      end
    end
  end
endmodule

// File: doc/background_fade_ctrl.md
# background_fade_ctrl

Frame-synchronous brightness controller and pixel pipeline for the 16-entry grayscale background palette. It converts a 4-bit background pixel index to 12-bit RGB through the palette table, then scales the result by a brightness level. The level is stepped by a fade state machine that runs on frame boundaries. It sits between the background sprite address/ROM stage and the VGA colour mux, and drives the death/level-transition fade-to-black and fade-back.

## Interface
Parameters:
- FADE_STEP_FRAMES, 2, frames per brightness step (≥1)
- HOLD_FRAMES, 30, frames held at level 0 before fading back in (≥1)

Ports:
- Clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  frame sync level from VGA controller; rising edge marks frame boundary
- start_fade  in  1  single-cycle request to begin fade-out
- pix_index  in  4  palette index of current pixel
- pix_valid  in  1  pix_index valid this cycle
- red, green, blue  out  4 each  scaled colour
- rgb_valid  out  1  red/green/blue valid
- level  out  5  current brightness, 0..16
- busy  out  1  fade sequence in progress
- done  out  1  one-cycle pulse on return to full brightness

## Operation
- Palette table, index 0..15, each entry R=G=B: 0,D,7,F,4,A,1,5,E,9,3,B,6,8,C,F (hex).
- Frame edge: fe = vsync & ~vsync_d, with vsync_d a register (reset 0).
- States:
  - BRIGHT: level=16. start_fade=1 → FADE_OUT, frame counter cleared.
  - FADE_OUT: on each fe, counter++. When counter reaches FADE_STEP_FRAMES: level--, counter=0. Level reaching 0 → DARK, counter=0.
  - DARK: on each fe, counter++. When counter reaches HOLD_FRAMES → FADE_IN, counter=0.
  - FADE_IN: same stepping as FADE_OUT but level++. Level reaching 16 → BRIGHT, done=1 for that cycle.
- start_fade outside BRIGHT is ignored; no queuing.
- Scaling: per channel, product = c(4b) × level(5b) = 9 bits; output = product[7:4].
  - Level 16 returns c exactly.
  - Level 0 returns 0.
- busy = (state != BRIGHT).

## Timing
- Reset values: state BRIGHT, level 16, counter 0, red/green/blue 0, rgb_valid 0, busy 0, done 0, vsync_d 0.
- Pixel latency is fixed at 2 cycles, fully pipelined, one pixel per cycle, no stalls:
  - Stage 1 registers the palette lookup and valid.
  - Stage 2 registers the scaled RGB and rgb_valid.
- rgb_valid = pix_valid delayed 2 cycles. RGB holds its last value while rgb_valid=0.
- Level changes only in the cycle following a fe. The stage-2 multiply uses the registered level, so a pixel in stage 1 at the edge uses the new level.
- start_fade coincident with fe: start accepted, that edge is not counted. The first step occurs FADE_STEP_FRAMES edges later.
- Full sequence from start is 16·FADE_STEP_FRAMES + HOLD_FRAMES + 16·FADE_STEP_FRAMES frame edges.
- Reset asserted mid-fade: immediate return to reset values, and the pipeline is flushed (rgb_valid 0).
- Counter width is sized for max(FADE_STEP_FRAMES, HOLD_FRAMES). The counter never wraps because comparison is by equality before increment.

## Configuration
- FADE_FLASH_EN defined:
  - Adds input `flash` (1 bit).
  - A flash pulse arms a flag. The next fe sets flash_active for exactly one frame, until the following fe.
  - While flash_active, stage 2 outputs F,F,F for every valid pixel, regardless of level or state.
  - The fade FSM continues unaffected.
  - flash during an active flash re-arms for the following frame.
- FADE_FLASH_EN undefined: no `flash` port, no flash logic, and output is always the scaled palette value.

## Test plan
- Reset: hold reset_n=0 with toggling inputs → all outputs at reset values, level=16. Release, then pix_index=3 with pix_valid → F,F,F with rgb_valid 2 cycles later.
- Table sweep at level 16: indices 0..15 back-to-back → outputs match the table in order, 2-cycle latency, no bubbles.
- Full fade (FADE_STEP_FRAMES=1, HOLD_FRAMES=2): pulse start_fade, then drive vsync edges:
  - After 8 edges level=8 and index 3 → 7,7,7; index 1 (D) → 6,6,6.
  - After 16 edges level=0 → 0,0,0.
  - After 34 edges level=16, with one done pulse; busy high from start until done.
- start_fade pulsed during FADE_OUT and DARK → ignored, sequence length unchanged (34 edges).
- Reset asserted at level 5 during FADE_IN → level 16 and busy 0 immediately; a new start_fade after release runs a full sequence.
- With FADE_FLASH_EN at level 8: pulse flash → next frame index 6 (value 1) outputs F,F,F, and the following frame outputs 0,0,0.
